// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward rx frame buffer that commits clean frames,
// rolls back errored or overflowing ones, and replays committed bytes on AXI-Stream.
module eth_rx_frame_fifo #(
    parameter int DEPTH_LOG2 = 11,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_axis_tdata,
    input  logic                  rx_axis_tvalid,
    input  logic                  rx_axis_tlast,
    input  logic                  rx_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic [CNT_W-1:0]      frames_ok,
    output logic [CNT_W-1:0]      frames_bad,
    output logic [CNT_W-1:0]      frames_ovf
);
    localparam logic [DEPTH_LOG2:0] SIZE = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t state, state_next;
    logic [DEPTH_LOG2:0] wr_ptr, wr_commit, rd_ptr;
    logic [8:0] mem [0:(1 << DEPTH_LOG2) - 1];
    logic full, wr_en, commit, bad, ovf, rollback, rd_en, out_valid;

    assign fill_level = wr_ptr - rd_ptr;
    assign full = fill_level == SIZE;
    assign rd_en = rd_ptr != wr_commit && (!out_valid || m_axis_tready);
    assign m_axis_tvalid = out_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    // any tlast ends the frame; a full buffer (or an earlier overflow) drops the rest
    always_comb begin
        state_next = state;
        if (rx_axis_tvalid)
            state_next = rx_axis_tlast ? IDLE : (state == DROP || full) ? DROP : RECV;
    end

    always_comb begin
        wr_en = rx_axis_tvalid && state != DROP && !full;
        commit = wr_en && rx_axis_tlast && !rx_axis_tuser;
        bad = wr_en && rx_axis_tlast && rx_axis_tuser;
        ovf = rx_axis_tvalid && rx_axis_tlast && (state == DROP || full);
        rollback = bad || (rx_axis_tvalid && state != DROP && full);
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {rx_axis_tlast, rx_axis_tdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            wr_commit <= '0;
            rd_ptr <= '0;
            frames_ok <= '0;
            frames_bad <= '0;
            frames_ovf <= '0;
        end else begin
            wr_ptr <= rollback ? wr_commit : wr_en ? wr_ptr + 1'b1 : wr_ptr;
            if (commit) wr_commit <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            frames_ok <= frames_ok + CNT_W'(commit && !(&frames_ok));
            frames_bad <= frames_bad + CNT_W'(bad && !(&frames_bad));
            frames_ovf <= frames_ovf + CNT_W'(ovf && !(&frames_ovf));
        end
    end

    // a byte leaves the buffer as soon as it is loaded into the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
        end else if (rd_en) begin
            out_valid <= 1'b1;
            {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        end else if (m_axis_tready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo: drives a 2048-byte and a 16-byte instance with the same rx stream
// and checks both against a queue-level model of committed, pending and dropped frames.
module tb_eth_rx_frame_fifo;
    localparam int N = 8192;

    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] rx_tdata = '0;
    logic rx_tvalid = 1'b0, rx_tlast = 1'b0, rx_tuser = 1'b0, m_tready = 1'b0;
    logic [7:0] td0, td1;
    logic tv0, tv1, tl0, tl1;
    logic [11:0] fl0;
    logic [4:0] fl1;
    logic [15:0] ok0, bad0, ovf0, ok1, bad1, ovf1;

    always #5 clk = ~clk;

    eth_rx_frame_fifo #(.DEPTH_LOG2(11), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .rx_axis_tdata(rx_tdata), .rx_axis_tvalid(rx_tvalid),
        .rx_axis_tlast(rx_tlast), .rx_axis_tuser(rx_tuser), .m_axis_tdata(td0),
        .m_axis_tvalid(tv0), .m_axis_tready(m_tready), .m_axis_tlast(tl0), .fill_level(fl0),
        .frames_ok(ok0), .frames_bad(bad0), .frames_ovf(ovf0));

    eth_rx_frame_fifo #(.DEPTH_LOG2(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .rx_axis_tdata(rx_tdata), .rx_axis_tvalid(rx_tvalid),
        .rx_axis_tlast(rx_tlast), .rx_axis_tuser(rx_tuser), .m_axis_tdata(td1),
        .m_axis_tvalid(tv1), .m_axis_tready(m_tready), .m_axis_tlast(tl1), .fill_level(fl1),
        .frames_ok(ok1), .frames_bad(bad1), .frames_ovf(ovf1));

    // model: committed bytes not yet handed out, bytes of the frame in progress, output register
    logic [8:0] cq [2][N];
    logic [8:0] pq [2][N];
    int ch [2], ct [2], pn [2], mok [2], mbad [2], movf [2];
    bit drop [2], mov [2];
    logic mlast [2];
    logic [7:0] mdat [2];

    function automatic int sat(int x);
        return x < 65535 ? x + 1 : x;
    endfunction

    always @(posedge clk) begin
        int cap;
        bit mfull;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ch[i] = 0; ct[i] = 0; pn[i] = 0; drop[i] = 0; mov[i] = 0;
                mdat[i] = '0; mlast[i] = 1'b0; mok[i] = 0; mbad[i] = 0; movf[i] = 0;
            end else begin
                cap = i ? 16 : 2048;
                mfull = (ct[i] - ch[i] + pn[i]) == cap;
                if (ct[i] != ch[i] && (!mov[i] || m_tready)) begin
                    {mlast[i], mdat[i]} = cq[i][ch[i] % N];
                    mov[i] = 1;
                    ch[i]++;
                end else if (m_tready) mov[i] = 0;
                if (rx_tvalid) begin
                    if (drop[i]) begin
                        if (rx_tlast) begin drop[i] = 0; movf[i] = sat(movf[i]); end
                    end else if (mfull) begin
                        pn[i] = 0;
                        if (rx_tlast) movf[i] = sat(movf[i]);
                        else drop[i] = 1;
                    end else begin
                        pq[i][pn[i]] = {rx_tlast, rx_tdata};
                        pn[i]++;
                        if (rx_tlast) begin
                            if (rx_tuser) mbad[i] = sat(mbad[i]);
                            else begin
                                for (int k = 0; k < pn[i]; k++) begin
                                    cq[i][ct[i] % N] = pq[i][k];
                                    ct[i]++;
                                end
                                mok[i] = sat(mok[i]);
                            end
                            pn[i] = 0;
                        end
                    end
                end
            end
        end
    end

    int beats [2], lasts [2];
    always @(posedge clk) begin
        if (tv0 && m_tready) begin beats[0]++; if (tl0) lasts[0]++; end
        if (tv1 && m_tready) begin beats[1]++; if (tl1) lasts[1]++; end
    end

    int checks = 0, errors = 0;
    bit lit_en = 0;
    string lit_name = "";
    int lit_act = 0, lit_exp = 0;

    task automatic chk(string n, int i, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got %0d expected %0d", n, i, $time, a, e);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("tvalid", i, i ? tv1 : tv0, mov[i]);
            if (mov[i]) begin
                chk("tdata", i, i ? td1 : td0, mdat[i]);
                chk("tlast", i, i ? tl1 : tl0, mlast[i]);
            end
            chk("fill_level", i, i ? fl1 : fl0, ct[i] - ch[i] + pn[i]);
            chk("frames_ok", i, i ? ok1 : ok0, mok[i]);
            chk("frames_bad", i, i ? bad1 : bad0, mbad[i]);
            chk("frames_ovf", i, i ? ovf1 : ovf0, movf[i]);
        end
        if (lit_en) chk(lit_name, 2, lit_act, lit_exp);
    end

    bit rnd = 0;
    int rdy_pct = 50;

    task automatic tick();
        @(posedge clk);
        #2;
        if (rnd) m_tready = $urandom_range(0, 99) < rdy_pct;
    endtask

    task automatic lit(string n, int a, int e);
        lit_name = n; lit_act = a; lit_exp = e; lit_en = 1;
        @(posedge clk);
        #2;
        lit_en = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic send(int len, int stop, int base, bit err, int gap);
        for (int k = 0; k < stop; k++) begin
            while ($urandom_range(0, 99) < gap) begin
                rx_tvalid = 0; rx_tdata = 8'($urandom); rx_tlast = 1'($urandom); rx_tuser = 1'($urandom);
                tick();
            end
            rx_tvalid = 1;
            rx_tdata = 8'(base + k);
            rx_tlast = k == len - 1;
            rx_tuser = (k == len - 1) ? err : 1'($urandom);
            tick();
        end
        rx_tvalid = 0; rx_tlast = 0; rx_tuser = 0;
    endtask

    task automatic drain();
        int t = 0;
        rnd = 0;
        m_tready = 1;
        while ((tv0 || tv1 || fl0 != 0 || fl1 != 0) && t < 5000) begin tick(); t++; end
        lit("drained", int'(t < 5000), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int b0, b1, l0, lat, t, len;
        tick(); tick();
        rst = 0;
        lit("rst_tvalid", tv0, 0);
        lit("rst_tdata", td0, 0);
        lit("rst_fill", fl1, 0);

        // 64-byte good frame: fits A, overflows B
        m_tready = 1; b0 = beats[0]; l0 = lasts[0];
        send(64, 64, 0, 0, 0);
        lat = 1;
        while (!tv0 && lat < 10) begin tick(); lat++; end
        lit("latency", lat, 2);
        drain();
        lit("t1_beats_a", beats[0] - b0, 64);
        lit("t1_lasts_a", lasts[0] - l0, 1);
        lit("t1_ok_a", ok0, 1);
        lit("t1_ovf_b", ovf1, 1);
        lit("t1_fill_a", fl0, 0);

        // good 10, bad 20, good 5
        do_reset();
        m_tready = 1; b0 = beats[0]; l0 = lasts[0];
        send(10, 10, 8'h10, 0, 20);
        send(20, 20, 8'h40, 1, 20);
        send(5, 5, 8'h90, 0, 20);
        drain();
        lit("t2_beats_a", beats[0] - b0, 15);
        lit("t2_lasts_a", lasts[0] - l0, 2);
        lit("t2_ok_a", ok0, 2);
        lit("t2_bad_a", bad0, 1);
        lit("t2_ovf_b", ovf1, 1);

        // 20-byte frame into the 16-byte buffer with no reader, then an 8-byte frame
        do_reset();
        m_tready = 0; b0 = beats[0]; b1 = beats[1];
        send(20, 20, 0, 0, 0);
        tick(); tick();
        lit("t3_fill_b", fl1, 0);
        lit("t3_tvalid_b", tv1, 0);
        lit("t3_ovf_b", ovf1, 1);
        lit("t3_fill_a", fl0, 19);
        send(8, 8, 8'hC0, 0, 0);
        tick(); tick();
        lit("t3_tvalid_b2", tv1, 1);
        lit("t3_tdata_b2", td1, 8'hC0);
        drain();
        lit("t3_beats_b", beats[1] - b1, 8);
        lit("t3_beats_a", beats[0] - b0, 28);

        // two 16-byte frames with random backpressure, wrapping the small buffer
        do_reset();
        b1 = beats[1];
        rnd = 1; rdy_pct = 50;
        send(16, 16, 8'h00, 0, 0);
        t = 0;
        while (fl1 != 0 && t < 500) begin tick(); t++; end
        lit("t4_b_emptied", int'(t < 500), 1);
        send(16, 16, 8'h10, 0, 0);
        drain();
        lit("t4_beats_b", beats[1] - b1, 32);
        lit("t4_ok_b", ok1, 2);
        lit("t4_ovf_b", ovf1, 0);

        // single-byte frame
        do_reset();
        m_tready = 0; b0 = beats[0];
        send(1, 1, 8'hA5, 0, 0);
        tick(); tick();
        lit("t5_tvalid_a", tv0, 1);
        lit("t5_tdata_a", td0, 8'hA5);
        lit("t5_tlast_a", tl0, 1);
        drain();
        lit("t5_ok_a", ok0, 1);
        lit("t5_ok_b", ok1, 1);
        lit("t5_beats_a", beats[0] - b0, 1);

        // reset in the middle of a 60-byte frame, then a 12-byte frame
        do_reset();
        m_tready = 1; b0 = beats[0]; l0 = lasts[0];
        send(60, 30, 0, 0, 0);
        rst = 1; rx_tvalid = 1; rx_tdata = 8'hEE;
        tick();
        rst = 0; rx_tvalid = 0;
        send(12, 12, 8'h50, 0, 0);
        drain();
        lit("t6_beats_a", beats[0] - b0, 12);
        lit("t6_lasts_a", lasts[0] - l0, 1);
        lit("t6_ok_a", ok0, 1);
        lit("t6_bad_a", bad0, 0);
        lit("t6_ovf_a", ovf0, 0);
        lit("t6_ok_b", ok1, 1);
        lit("t6_ovf_b", ovf1, 0);

        // frame larger than the 2048-byte buffer always overflows
        b0 = beats[0];
        send(2100, 2100, 0, 0, 0);
        drain();
        lit("t7_ovf_a", ovf0, 1);
        lit("t7_beats_a", beats[0] - b0, 0);

        // random traffic
        rnd = 1;
        for (int f = 0; f < 80; f++) begin
            rdy_pct = $urandom_range(10, 100);
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 300) : $urandom_range(1, 40);
            send(len, len, $urandom_range(0, 255), $urandom_range(0, 4) == 0, $urandom_range(0, 30));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
